// File: rtl/ram_tx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_tx_seq_pkg
// Description : Shared state encoding and limits for the RAM-to-UART sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_tx_seq_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_TX   = 3'd5
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_tx_seq_handshake.sv
`default_nettype none
// ============================================================================
// Module      : ram_tx_seq_handshake
// Description : tx_start/tx_busy handshake with the UART (ISSUE, WAIT_ACK,
//               WAIT_TX); returns the next handshake state and a byte-done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_tx_seq_handshake
    import ram_tx_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  seq_state_e i_state,
    input  logic       i_launch,
    input  logic       i_tx_busy,
    output seq_state_e o_state_d,
    output logic       o_byte_done,
    output logic       o_tx_start
);

    logic r_tx_start_q;
    logic w_tx_start_d;

    // When the UART is already idle at capture time the request is issued
    // straight away, so the tx_start cycle is spent in WAIT_ACK.
    always_comb begin
        o_state_d    = i_state;
        o_byte_done  = 1'b0;
        w_tx_start_d = 1'b0;
        case (i_state)
            ST_WAIT_DATA, ST_ISSUE: begin
                if ((i_state == ST_ISSUE) || i_launch) begin
                    if (!i_tx_busy) begin
                        w_tx_start_d = 1'b1;
                        o_state_d    = ST_WAIT_ACK;
                    end else begin
                        o_state_d    = ST_ISSUE;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (i_tx_busy) begin
                    o_state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                o_byte_done = !i_tx_busy;
            end
            default: begin
                o_state_d = i_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_start_q <= 1'b0;
        end else begin
            r_tx_start_q <= w_tx_start_d;
        end
    end

    assign o_tx_start = r_tx_start_q;

endmodule
`default_nettype wire

// File: rtl/ram_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_tx_sequencer
// Description : Reads len bytes from a synchronous RAM and feeds them one at a
//               time to a UART transmitter. Optional looping: RAM_TX_SEQ_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_tx_sequencer
    import ram_tx_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              loop_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int         c_LAT_EFF  = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                        ((RD_LAT < 1) ? 1 : RD_LAT);
    localparam logic [1:0] c_LAT_LAST = 2'(c_LAT_EFF - 1);

    seq_state_e        r_state_q, w_state_d, w_hs_state_d;
    logic [ADDR_W-1:0] r_addr_q, w_addr_d;
    logic [LEN_W-1:0]  r_rem_q, w_rem_d;
    logic [1:0]        r_lat_q, w_lat_d;
    logic [DATA_W-1:0] r_data_q, w_data_d;
    logic              r_abort_q, w_abort_d;
    logic              r_rd_en_q, w_rd_en_d;
    logic              r_busy_q, w_busy_d;
    logic              r_done_q, w_done_d;
    logic              r_aborted_q, w_aborted_d;
    logic              w_abort_any, w_capture, w_launch, w_byte_done;

`ifdef RAM_TX_SEQ_LOOP_EN
    logic [ADDR_W-1:0] r_base_addr_q, w_base_addr_d;
    logic [LEN_W-1:0]  r_base_len_q, w_base_len_d;
`else
    logic w_unused_loop_en;
    assign w_unused_loop_en = loop_en;
`endif

    assign w_abort_any = r_abort_q | abort;
    assign w_capture   = (r_state_q == ST_WAIT_DATA) && (r_lat_q == c_LAT_LAST);
    assign w_launch    = w_capture & ~w_abort_any;

    ram_tx_seq_handshake u_handshake (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_state     (r_state_q),
        .i_launch    (w_launch),
        .i_tx_busy   (tx_busy),
        .o_state_d   (w_hs_state_d),
        .o_byte_done (w_byte_done),
        .o_tx_start  (tx_start)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_addr_d    = r_addr_q;
        w_rem_d     = r_rem_q;
        w_lat_d     = r_lat_q;
        w_data_d    = r_data_q;
        w_abort_d   = (r_state_q == ST_IDLE) ? r_abort_q : w_abort_any;
        w_aborted_d = r_aborted_q;
        w_done_d    = 1'b0;
`ifdef RAM_TX_SEQ_LOOP_EN
        w_base_addr_d = r_base_addr_q;
        w_base_len_d  = r_base_len_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_addr_d    = start_addr;
                    w_rem_d     = len;
                    w_abort_d   = 1'b0;
                    w_aborted_d = 1'b0;
`ifdef RAM_TX_SEQ_LOOP_EN
                    w_base_addr_d = start_addr;
                    w_base_len_d  = len;
`endif
                    if (len == '0) begin
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_lat_d   = 2'd0;
                w_state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (!w_capture) begin
                    w_lat_d = r_lat_q + 2'd1;
                end else if (w_abort_any) begin
                    // The read completes but its byte is dropped.
                    w_state_d   = ST_IDLE;
                    w_done_d    = 1'b1;
                    w_aborted_d = 1'b1;
                end else begin
                    w_data_d  = ram_rd_data;
                    w_state_d = w_hs_state_d;
                end
            end
            ST_ISSUE, ST_WAIT_ACK: begin
                w_state_d = w_hs_state_d;
            end
            ST_WAIT_TX: begin
                if (w_byte_done) begin
                    w_addr_d = r_addr_q + ADDR_W'(1);
                    w_rem_d  = r_rem_q - LEN_W'(1);
                    if ((r_rem_q == LEN_W'(1)) || w_abort_any) begin
                        w_done_d    = 1'b1;
                        w_aborted_d = w_abort_any;
                        w_state_d   = ST_IDLE;
`ifdef RAM_TX_SEQ_LOOP_EN
                        if (loop_en && !w_abort_any) begin
                            w_addr_d  = r_base_addr_q;
                            w_rem_d   = r_base_len_q;
                            w_state_d = ST_READ;
                        end
`endif
                    end else begin
                        w_state_d = ST_READ;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_rd_en_d = (w_state_d == ST_READ);
        w_busy_d  = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q   <= ST_IDLE;
            r_addr_q    <= '0;
            r_rem_q     <= '0;
            r_lat_q     <= '0;
            r_data_q    <= '0;
            r_abort_q   <= 1'b0;
            r_rd_en_q   <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_aborted_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_rem_q     <= w_rem_d;
            r_lat_q     <= w_lat_d;
            r_data_q    <= w_data_d;
            r_abort_q   <= w_abort_d;
            r_rd_en_q   <= w_rd_en_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_aborted_q <= w_aborted_d;
        end
    end

`ifdef RAM_TX_SEQ_LOOP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base_addr_q <= '0;
            r_base_len_q  <= '0;
        end else begin
            r_base_addr_q <= w_base_addr_d;
            r_base_len_q  <= w_base_len_d;
        end
    end
`endif

    assign ram_rd_en = r_rd_en_q;
    assign ram_addr  = r_addr_q;
    assign tx_data   = r_data_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;
    assign aborted   = r_aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_tx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_tx_sequencer
// Description : Self-checking bench: RAM and UART models plus a transfer-level
//               reference model for ram_tx_sequencer (RAM_TX_SEQ_LOOP_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_tx_sequencer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, loop_en;
    logic [ADDR_W-1:0] start_addr, ram_addr;
    logic [LEN_W-1:0]  len;
    logic              ram_rd_en, tx_start, tx_busy, busy, done, aborted;
    logic [DATA_W-1:0] ram_rd_data, tx_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_tx_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .abort       (abort),
        .loop_en     (loop_en),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    // RAM model: data is valid exactly RD_LAT cycles after the strobe, junk otherwise.
    logic [DATA_W-1:0] mem  [256];
    logic [DATA_W-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= ram_rd_en ? mem[ram_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rd_data = pipe[RD_LAT-1];

    // UART model: busy for blen cycles starting ack_dly cycles after tx_start.
    int   cyc = 0;
    int   busy_from = -10;
    int   busy_to   = -10;
    int   ack_dly = 0;
    int   blen = 3;
    logic force_busy = 1'b0;
    assign tx_busy = force_busy | ((cyc >= busy_from) && (cyc <= busy_to));

    logic [DATA_W-1:0] tx_log [$];
    int                tx_cyc [$];
    logic [ADDR_W-1:0] rd_log [$];
    int                rd_cyc [$];
    int                done_cyc [$];
    logic              done_ab [$];
    int                busy_hi = 0;
    int                overlap = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (tx_start) begin
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
                busy_from <= cyc + 1 + ack_dly;
                busy_to   <= cyc + ack_dly + blen;
                if (tx_busy) overlap <= overlap + 1;
            end
            if (ram_rd_en) begin
                rd_log.push_back(ram_addr);
                rd_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_ab.push_back(aborted);
            end
            if (busy) busy_hi <= busy_hi + 1;
        end
    end

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete(); rd_log.delete(); rd_cyc.delete();
        done_cyc.delete(); done_ab.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input int n, output int sc);
        @(negedge clk);
        start = 1'b1; start_addr = a; len = LEN_W'(n); sc = cyc;
        @(negedge clk);
        start = 1'b0; start_addr = ADDR_W'($urandom); len = LEN_W'($urandom);
    endtask

    task automatic wait_dones(input int n, output bit to);
        int k;
        k = 0;
        while (done_cyc.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        to = (done_cyc.size() < n);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] ref_byte(input logic [ADDR_W-1:0] a, input int i);
        logic [ADDR_W-1:0] ai;
        ai = a + ADDR_W'(i);
        return mem[ai];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ram_rd_en); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", ram_addr); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, aborted}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        int sc, b0; bit to;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3;
        ack_dly = 1; blen = 4;
        clear_logs(); b0 = busy_hi;
        do_start(8'h10, 3, sc);
        wait_dones(1, to);
        checks++; if (to) begin errors++; $display("FAIL dir_timeout: got %0d dones expected 1", done_cyc.size()); end
        checks++;
        if (tx_log.size() != 3 || tx_log[0] !== 8'hA1 || tx_log[1] !== 8'hA2 || tx_log[2] !== 8'hA3) begin
            errors++; $display("FAIL dir_bytes: got %p expected A1,A2,A3", tx_log);
        end
        checks++;
        if (rd_log.size() != 3 || rd_log[0] !== 8'h10 || rd_log[1] !== 8'h11 || rd_log[2] !== 8'h12) begin
            errors++; $display("FAIL dir_addrs: got %p expected 10,11,12", rd_log);
        end
        checks++; if (rd_cyc.size() < 1 || rd_cyc[0] != sc + 1) begin errors++; $display("FAIL dir_first_read: got %p expected %0d", rd_cyc, sc + 1); end
        checks++; if (tx_cyc.size() < 1 || tx_cyc[0] != sc + 2 + RD_LAT) begin errors++; $display("FAIL dir_first_tx: got %p expected %0d", tx_cyc, sc + 2 + RD_LAT); end
        checks++; if (done_ab.size() != 1 || done_ab[0] !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL dir_aborted: got %p/%b expected 0", done_ab, aborted); end
        checks++;
        if (done_cyc.size() < 1 || busy_hi - b0 != done_cyc[0] - sc - 1) begin
            errors++; $display("FAIL dir_busy_span: got %0d expected %0d", busy_hi - b0, done_cyc.size() > 0 ? done_cyc[0] - sc - 1 : -1);
        end
    endtask

    task automatic test_len_zero();
        int sc, b0; bit to;
        clear_logs(); b0 = busy_hi;
        do_start(ADDR_W'($urandom), 0, sc);
        wait_dones(1, to);
        repeat (5) @(negedge clk);
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != sc + 1) begin errors++; $display("FAIL len0_done: got %p expected %0d", done_cyc, sc + 1); end
        checks++; if (rd_log.size() != 0 || tx_log.size() != 0) begin errors++; $display("FAIL len0_activity: got %0d reads %0d tx expected 0 0", rd_log.size(), tx_log.size()); end
        checks++; if (busy_hi != b0) begin errors++; $display("FAIL len0_busy: got %0d busy cycles expected 0", busy_hi - b0); end
    endtask

    task automatic test_wrap();
        int sc; bit to; bit bad;
        ack_dly = 0; blen = 2;
        clear_logs();
        do_start(8'hFE, 4, sc);
        wait_dones(1, to);
        bad = (rd_log.size() != 4);
        if (!bad) bad = (rd_log[0] !== 8'hFE || rd_log[1] !== 8'hFF || rd_log[2] !== 8'h00 || rd_log[3] !== 8'h01);
        checks++; if (to || bad) begin errors++; $display("FAIL wrap_addrs: got %p expected FE,FF,00,01", rd_log); end
        bad = (tx_log.size() != 4);
        for (int i = 0; i < 4 && !bad; i++) bad = (tx_log[i] !== ref_byte(8'hFE, i));
        checks++; if (bad) begin errors++; $display("FAIL wrap_bytes: got %p", tx_log); end
    endtask

    task automatic test_random();
        int sc, n, exp_t, exp_done; bit to, bad_b, bad_a, bad_t;
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < 8; t++) begin
            a = ADDR_W'($urandom); n = $urandom_range(1, 6);
            ack_dly = $urandom_range(0, 2); blen = $urandom_range(1, 5);
            clear_logs();
            do_start(a, n, sc);
            wait_dones(1, to);
            bad_b = (tx_log.size() != n); bad_a = (rd_log.size() != n); bad_t = bad_b;
            exp_t = sc + 2 + RD_LAT;
            for (int i = 0; i < n; i++) begin
                if (!bad_b) bad_b = (tx_log[i] !== ref_byte(a, i));
                if (!bad_a) bad_a = (rd_log[i] !== a + ADDR_W'(i));
                if (!bad_t) bad_t = (tx_cyc[i] != exp_t);
                // next byte: 2+RD_LAT cycles after busy falls (busy falls at tx+ack+blen+1)
                exp_t = exp_t + ack_dly + blen + 3 + RD_LAT;
            end
            exp_done = exp_t - (3 + RD_LAT) + 2;
            checks++; if (to || bad_b) begin errors++; $display("FAIL rand%0d_bytes: got %p n=%0d addr=%0h", t, tx_log, n, a); end
            checks++; if (bad_a) begin errors++; $display("FAIL rand%0d_addrs: got %p start=%0h n=%0d", t, rd_log, a, n); end
            checks++; if (bad_t) begin errors++; $display("FAIL rand%0d_tx_timing: got %p start_cyc=%0d", t, tx_cyc, sc); end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != exp_done || done_ab[0] !== 1'b0) begin
                errors++; $display("FAIL rand%0d_done: got %p/%p expected cycle %0d aborted 0", t, done_cyc, done_ab, exp_done);
            end
        end
    endtask

    task automatic test_abort();
        int sc, k; bit to;
        logic [ADDR_W-1:0] a;
        // abort during the second byte's transmission, plus an ignored start
        a = ADDR_W'($urandom); ack_dly = 1; blen = 4;
        clear_logs();
        do_start(a, 5, sc);
        repeat (2) @(negedge clk);
        start = 1'b1; start_addr = a + 8'h40; len = LEN_W'(9);
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(tx_log.size() == 2 && tx_busy) && k < 500) begin @(negedge clk); k++; end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_dones(1, to);
        repeat (10) @(negedge clk);
        checks++;
        if (to || tx_log.size() != 2 || tx_log[0] !== ref_byte(a, 0) || tx_log[1] !== ref_byte(a, 1)) begin
            errors++; $display("FAIL abort_tx_bytes: got %p expected 2 bytes from %0h", tx_log, a);
        end
        checks++; if (done_ab.size() != 1 || done_ab[0] !== 1'b1) begin errors++; $display("FAIL abort_status: got %p expected one done with aborted=1", done_ab); end
        checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_hold: got aborted=%b busy=%b expected 1 0", aborted, busy); end

        // abort while the third read is in flight: that byte is never sent
        a = ADDR_W'($urandom); ack_dly = 0; blen = 2;
        clear_logs();
        do_start(a, 6, sc);
        k = 0;
        while (rd_log.size() < 3 && k < 500) begin @(negedge clk); k++; end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_dones(1, to);
        checks++; if (to || tx_log.size() != 2 || rd_log.size() != 3) begin errors++; $display("FAIL abort_read: got %0d tx %0d reads expected 2 3", tx_log.size(), rd_log.size()); end
        checks++; if (done_ab.size() != 1 || done_ab[0] !== 1'b1) begin errors++; $display("FAIL abort_read_status: got %p expected 1", done_ab); end

        // abort in IDLE is ignored; the next start clears aborted
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        a = ADDR_W'($urandom);
        clear_logs();
        do_start(a, 2, sc);
        wait_dones(1, to);
        checks++; if (to || tx_log.size() != 2 || done_ab[0] !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL idle_abort: got %0d bytes aborted %p expected 2 0", tx_log.size(), done_ab); end
    endtask

    task automatic test_busy_hold();
        int sc, f, k; bit to;
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom); ack_dly = 0; blen = 3;
        clear_logs();
        @(negedge clk); force_busy = 1'b1;
        do_start(a, 1, sc);
        repeat (20) @(negedge clk);
        checks++; if (tx_log.size() != 0) begin errors++; $display("FAIL hold_no_start: got %0d tx_start expected 0", tx_log.size()); end
        @(posedge clk); #1; force_busy = 1'b0; f = cyc;
        wait_dones(1, to);
        k = (tx_cyc.size() > 0) ? tx_cyc[0] : -1;
        checks++; if (to || k != f + 1) begin errors++; $display("FAIL hold_release: got tx_start at %0d expected %0d", k, f + 1); end
        checks++; if (tx_log.size() != 1 || tx_log[0] !== ref_byte(a, 0)) begin errors++; $display("FAIL hold_byte: got %p expected %0h", tx_log, ref_byte(a, 0)); end
    endtask

    task automatic test_loop();
        int sc, k, b0; bit to, bad;
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom); ack_dly = 1; blen = 2;
        clear_logs(); b0 = busy_hi;
        loop_en = 1'b1;
        do_start(a, 2, sc);
`ifdef RAM_TX_SEQ_LOOP_EN
        wait_dones(1, to);
        start = 1'b1; start_addr = a + 8'h20; len = LEN_W'(1);
        @(negedge clk); start = 1'b0;
        wait_dones(3, to);
        k = 0;
        while (!(tx_log.size() == 7 && tx_busy) && k < 500) begin @(negedge clk); k++; end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_dones(4, to);
        repeat (10) @(negedge clk);
        bad = (tx_log.size() != 7);
        for (int i = 0; i < 7 && !bad; i++) bad = (tx_log[i] !== ref_byte(a, i % 2));
        checks++; if (to || bad) begin errors++; $display("FAIL loop_bytes: got %p", tx_log); end
        bad = (done_ab.size() != 4);
        if (!bad) bad = (done_ab[0] !== 1'b0 || done_ab[1] !== 1'b0 || done_ab[2] !== 1'b0 || done_ab[3] !== 1'b1);
        checks++; if (bad) begin errors++; $display("FAIL loop_dones: got %p expected 0,0,0,1", done_ab); end
        checks++;
        if (done_cyc.size() != 4 || busy_hi - b0 != done_cyc[3] - sc - 1) begin
            errors++; $display("FAIL loop_busy: got %0d busy cycles dones %p", busy_hi - b0, done_cyc);
        end
`else
        wait_dones(1, to);
        repeat (30) @(negedge clk);
        checks++; if (to || tx_log.size() != 2 || done_cyc.size() != 1) begin errors++; $display("FAIL noloop: got %0d bytes %0d dones expected 2 1", tx_log.size(), done_cyc.size()); end
        checks++; if (busy !== 1'b0 || done_ab[0] !== 1'b0) begin errors++; $display("FAIL noloop_idle: got busy=%b aborted=%p expected 0 0", busy, done_ab); end
`endif
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sc, k, nrd; bit to;
        ack_dly = 0; blen = 6;
        clear_logs();
        do_start(ADDR_W'($urandom), 5, sc);
        k = 0;
        while (tx_log.size() < 1 && k < 500) begin @(negedge clk); k++; end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, tx_start, ram_rd_en, done} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs: got %b expected 0000", {busy, tx_start, ram_rd_en, done}); end
        nrd = rd_log.size();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (done_cyc.size() != 0 || rd_log.size() != nrd || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got %0d dones %0d new reads busy=%b expected 0 0 0", done_cyc.size(), rd_log.size() - nrd, busy); end
        to = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        start_addr = '0; len = '0;
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        test_reset();
        test_directed();
        test_len_zero();
        test_wrap();
        test_random();
        test_abort();
        test_busy_hold();
        test_loop();
        test_reset_mid();
        checks++; if (overlap != 0) begin errors++; $display("FAIL tx_start_while_busy: got %0d expected 0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_tx_sequencer.md
# ram_tx_sequencer

Parametrised RAM-to-UART transmit sequencer. On a start request it reads `len` bytes from a synchronous RAM beginning at `start_addr` and hands each byte to the UART transmitter over a start/busy handshake. Each byte goes out only after the previous one has fully left the transmitter. It sits between the frame buffer RAM and the UART TX core in the flash/UART datapath. It is a fully synchronous, single-clock successor to the edge-triggered address generator, adding arbitrary start address, programmable RAM latency, abort, done/status reporting and optional looping.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM/TX data width.
- `LEN_W`, `ADDR_W`+1: length width, so a full-depth transfer is expressible.
- `RD_LAT`, 1: RAM read latency in cycles, legal range 1..4.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address; sampled with `start`.
- `len`  in  LEN_W  byte count; sampled with `start`.
- `abort`  in  1  stop after the byte currently in flight.
- `loop_en`  in  1  repeat the transfer; used only with `RAM_TX_SEQ_LOOP_EN`.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_rd_data`  in  DATA_W  RAM read data, valid `RD_LAT` cycles after `ram_rd_en`.
- `tx_data`  out  DATA_W  byte presented to the UART.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  UART busy (same clock domain).
- `busy`  out  1  high from the accepted start until the done cycle.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  status of the last transfer; valid from `done` until the next accepted start.

## Operation
- States: IDLE, READ, WAIT_DATA, ISSUE, WAIT_ACK, WAIT_TX.
- **IDLE:**
  - On `start`, latch `start_addr` into `ram_addr` and `len` into `remaining`, and clear `aborted`.
  - If `len`==0, pulse `done` in the next cycle and stay in IDLE; otherwise go to READ.
- **READ:** `ram_rd_en`=1 for exactly one cycle, then WAIT_DATA.
- **WAIT_DATA:** count `RD_LAT` cycles, capture `ram_rd_data` into `tx_data`, then go to ISSUE.
- **ISSUE:**
  - Assert `tx_start` for one cycle, and only when `tx_busy`=0; otherwise hold in ISSUE.
  - Go to WAIT_ACK.
- **WAIT_ACK:** wait for `tx_busy`=1, then go to WAIT_TX.
- **WAIT_TX:** wait for `tx_busy`=0, then:
  - `ram_addr` increments modulo 2^ADDR_W (wraps past max) and `remaining` decrements.
  - If `remaining` was 1, or an abort is latched: pulse `done`, return to IDLE, and set `aborted` to the latch value.
  - Otherwise go to READ.
- **Abort:**
  - `abort` is latched in any non-IDLE state.
  - In READ or WAIT_DATA, a latched abort finishes the current read without sending it. The block goes to IDLE with `done`=1 and `aborted`=1.
  - An abort during ISSUE, WAIT_ACK or WAIT_TX completes that byte first.
- `start` while `busy`=1 is ignored.
- `abort` in IDLE is ignored.
- Reset mid-transfer:
  - Returns to IDLE immediately.
  - No `done` pulse is produced.
  - A byte already handed to the UART is not recalled.

## Timing
- Reset values: `ram_rd_en`=0, `ram_addr`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `done`=0, `aborted`=0, state IDLE, `remaining`=0.
- Start sampled at cycle 0: `busy`=1 and READ from cycle 1, with `ram_rd_en` in cycle 1.
- `tx_data` is valid from cycle 1+`RD_LAT`+1.
- `tx_start` is asserted at the earliest in cycle 2+`RD_LAT`.
- Byte-to-byte overhead is 2+`RD_LAT` cycles after `tx_busy` falls, plus the UART's own ack delay.
- `done` is asserted in the cycle after the final `tx_busy` falling edge is seen, together with `busy` falling.
- `tx_data` holds its value from `tx_start` until the next capture.

## Configuration
- `RAM_TX_SEQ_LOOP_EN` defined:
  - When the last byte completes with `loop_en`=1, `done` pulses (with `aborted`=0), `ram_addr` reloads from the latched start address, `remaining` reloads from the latched length, and the FSM goes to READ.
  - `busy` stays high throughout.
  - Only `abort` or reset ends the loop.
- Macro undefined: `loop_en` is ignored and each transfer ends at `len` bytes.

## Structure
- Package `ram_tx_seq_pkg` holds the state enum and the constant `RD_LAT_MAX`=4.
- The read-latency counter is inline, 2 bits.
- One natural sub-module: `ram_tx_seq_handshake`, containing ISSUE/WAIT_ACK/WAIT_TX and the `tx_start`/`tx_busy` protocol. The top keeps the address/length counters and the abort latch.

## Test plan
- `start_addr`=0x10, `len`=3, `RD_LAT`=1, RAM holds 0xA1,0xA2,0xA3 → three `tx_start` pulses carrying 0xA1,0xA2,0xA3; addresses 0x10..0x12; one `done` with `aborted`=0.
- `len`=0 → no `ram_rd_en` and no `tx_start`; `done` in cycle 1; `busy` never high.
- `start_addr`=0xFE, `len`=4 → addresses 0xFE,0xFF,0x00,0x01 (wrap).
- `len`=5, `abort` pulsed during the second byte's WAIT_TX → exactly 2 bytes sent, `done`=1, `aborted`=1.
- `tx_busy` held high for 20 cycles at ISSUE, with `RD_LAT`=3 → `tx_start` asserts only in the cycle after `tx_busy` drops; first `ram_rd_en` to data capture is exactly 3 cycles.
- With `RAM_TX_SEQ_LOOP_EN` and `loop_en`=1, `len`=2 → `done` pulses after bytes 2, 4, 6; a second `start` mid-loop is ignored; `abort` ends the loop after the current byte.
